// File: rtl/i2c_sensor_responder.sv
// I2C target emulating the 0x44 temperature/humidity sensor: accepts 16-bit
// commands and serves six-byte readings (T, CRC(T), H, CRC(H)) open-drain.
module i2c_sensor_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h44,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] t_code,
  input  logic [15:0] h_code,
  input  logic        code_load,
  output logic [15:0] cmd,
  output logic        cmd_valid,
  output logic        rd_done,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, CMD_RX, CMD_ACK, TX, TX_ACK, IGNORE} state_t;

  localparam logic [15:0] SOFT_RESET = 16'h30A2;

  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--)
      c = (c[7] ^ d[i]) ? ({c[6:0], 1'b0} ^ 8'h31) : {c[6:0], 1'b0};
    return c;
  endfunction

  function automatic logic [7:0] pick(input logic [47:0] s, input logic [2:0] i);
    case (i)
      3'd0:    pick = s[47:40];
      3'd1:    pick = s[39:32];
      3'd2:    pick = s[31:24];
      3'd3:    pick = s[23:16];
      3'd4:    pick = s[15:8];
      3'd5:    pick = s[7:0];
      default: pick = 8'h00;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_p, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic        rw_q, rw_d;
  logic [1:0]  cmd_idx_q, cmd_idx_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_byte_q, tx_byte_d, next_byte;
  logic        acked_q, acked_d;
  logic [15:0] cmd_shift_q, cmd_shift_d, cmd_d;
  logic        cmd_valid_d, rd_done_d, busy_d;
  logic        sda_oe_q, sda_oe_d;
  logic [47:0] sample_q, sample_d, shadow_q, shadow_d;
  logic        sample_ok_q, sample_ok_d;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

  // Gated with rst so SDA is released in the very cycle reset is asserted.
  assign sda_oe = sda_oe_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_p    <= 1'b1;
      sda_p    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_p    <= scl_s;
      sda_p    <= sda_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      cmd_idx_q   <= '0;
      tx_idx_q    <= '0;
      tx_byte_q   <= '0;
      acked_q     <= 1'b0;
      cmd_shift_q <= '0;
      cmd         <= '0;
      cmd_valid   <= 1'b0;
      rd_done     <= 1'b0;
      busy        <= 1'b0;
      sda_oe_q    <= 1'b0;
      sample_q    <= '0;
      shadow_q    <= '0;
      sample_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      cmd_idx_q   <= cmd_idx_d;
      tx_idx_q    <= tx_idx_d;
      tx_byte_q   <= tx_byte_d;
      acked_q     <= acked_d;
      cmd_shift_q <= cmd_shift_d;
      cmd         <= cmd_d;
      cmd_valid   <= cmd_valid_d;
      rd_done     <= rd_done_d;
      busy        <= busy_d;
      sda_oe_q    <= sda_oe_d;
      sample_q    <= sample_d;
      shadow_q    <= shadow_d;
      sample_ok_q <= sample_ok_d;
    end
  end

  // sda_oe only moves on a synchronised SCL fall (or START/STOP), so the
  // line is stable for the whole SCL-high window the master samples in.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    cmd_idx_d   = cmd_idx_q;
    tx_idx_d    = tx_idx_q;
    tx_byte_d   = tx_byte_q;
    acked_d     = acked_q;
    cmd_shift_d = cmd_shift_q;
    cmd_d       = cmd;
    cmd_valid_d = 1'b0;
    rd_done_d   = 1'b0;
    busy_d      = busy;
    sda_oe_d    = sda_oe_q;
    sample_d    = sample_q;
    shadow_d    = shadow_q;
    sample_ok_d = sample_ok_q;
    next_byte   = pick(shadow_q, tx_idx_q + 3'd1);

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      acked_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: sda_oe_d = 1'b0;
        ADDR: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            rw_d      = rx_q[0];
            if (rx_q[7:1] == DEV_ADDR && (!rx_q[0] || sample_ok_q)) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              if (rx_q[0]) shadow_d = sample_q;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d   = TX;
              tx_idx_d  = '0;
              tx_byte_d = shadow_q[47:40];
              sda_oe_d  = ~shadow_q[47];
            end else begin
              state_d   = CMD_RX;
              cmd_idx_d = '0;
              sda_oe_d  = 1'b0;
            end
          end
        end
        CMD_RX: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d   = CMD_ACK;
            sda_oe_d  = 1'b1;
            bit_cnt_d = '0;
            if (cmd_idx_q == 2'd0)      cmd_shift_d[15:8] = rx_q;
            else if (cmd_idx_q == 2'd1) cmd_shift_d[7:0]  = rx_q;
          end
        end
        CMD_ACK: begin
          if (scl_fall) begin
            state_d  = CMD_RX;
            sda_oe_d = 1'b0;
            if (cmd_idx_q == 2'd1) begin
              cmd_d       = cmd_shift_q;
              cmd_valid_d = 1'b1;
              if (cmd_shift_q == SOFT_RESET) sample_ok_d = 1'b0;
            end
            if (cmd_idx_q != 2'd2) cmd_idx_d = cmd_idx_q + 2'd1;
          end
        end
        TX: begin
          if (scl_rise) begin
            if (tx_byte_q[7] && !sda_s) state_d = IGNORE;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              state_d   = TX_ACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              acked_d   = 1'b0;
            end else begin
              tx_byte_d = {tx_byte_q[6:0], 1'b0};
              sda_oe_d  = ~tx_byte_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_s || tx_idx_q == 3'd5) begin
              state_d   = IGNORE;
              rd_done_d = (tx_idx_q == 3'd5);
            end else begin
              acked_d = 1'b1;
            end
          end else if (scl_fall && acked_q) begin
            state_d   = TX;
            tx_idx_d  = tx_idx_q + 3'd1;
            tx_byte_d = next_byte;
            sda_oe_d  = ~next_byte[7];
            bit_cnt_d = '0;
            acked_d   = 1'b0;
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: state_d  = IDLE;
      endcase
    end

    if (code_load) begin
      sample_d    = {t_code, crc8(t_code), h_code, crc8(h_code)};
      sample_ok_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Bench for i2c_sensor_responder: bit-banged I2C master, directed vector table,
// hand-written corner sequences and random transactions against a reference model.
module tb_i2c_sensor_responder;

  localparam int Q = 6;

  typedef enum {V_LOAD, V_WRITE, V_READ} kind_e;

  typedef struct {
    kind_e       kind;
    logic [6:0]  addr;
    int          n;
    logic [7:0]  d0, d1, d2;
    logic [15:0] t, h;
    logic        exp_ack;
    logic [15:0] exp_cmd;
    int          exp_cp;
    int          exp_rp;
    logic [47:0] exp_bytes;
  } vec_t;

  typedef struct {
    logic        addr_ack;
    logic        data_ack;
    logic        busy_mid;
    logic        busy_end;
    logic        oe_end;
    logic [15:0] cmd;
    int          cmd_d;
    int          rd_d;
    int          oe_d;
    logic [47:0] bytes;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [15:0] t_code = '0;
  logic [15:0] h_code = '0;
  logic        code_load = 1'b0;
  logic [15:0] cmd;
  logic        cmd_valid, rd_done, busy;

  int errors = 0;
  int checks = 0;
  int cmd_pulses = 0;
  int rd_pulses = 0;
  int oe_cycles = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_sensor_responder #(.DEV_ADDR(7'h44), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .t_code(t_code), .h_code(h_code), .code_load(code_load),
    .cmd(cmd), .cmd_valid(cmd_valid), .rd_done(rd_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid) cmd_pulses <= cmd_pulses + 1;
    if (rd_done)   rd_pulses  <= rd_pulses + 1;
    if (sda_oe)    oe_cycles  <= oe_cycles + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  // CRC-8/0x31 with init 0xFF, as polynomial long division over the message.
  function automatic logic [7:0] ref_crc(input logic [15:0] d);
    logic [23:0] r;
    r = {d[15:8] ^ 8'hFF, d[7:0], 8'h00};
    for (int i = 23; i >= 8; i--)
      if (r[i]) r = r ^ (24'h131 << (i - 8));
    return r[7:0];
  endfunction

  function automatic vec_t mk(kind_e k, logic [6:0] a, int n, logic [7:0] d0, logic [7:0] d1,
                              logic [7:0] d2, logic [15:0] t, logic [15:0] h, logic ack,
                              logic [15:0] c, int cp, int rp, logic [47:0] by);
    vec_t v;
    v.kind = k; v.addr = a; v.n = n; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.t = t; v.h = h;
    v.exp_ack = ack; v.exp_cmd = c; v.exp_cp = cp; v.exp_rp = rp; v.exp_bytes = by;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    waitq(Q); sda_m = 1'b1; waitq(Q); scl = 1'b1; waitq(Q); sda_m = 1'b0; waitq(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    waitq(Q); sda_m = 1'b0; waitq(Q); scl = 1'b1; waitq(Q); sda_m = 1'b1; waitq(Q);
  endtask

  task automatic write_bit(input logic b);
    waitq(Q); sda_m = b; waitq(Q); scl = 1'b1; waitq(2 * Q); scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    waitq(Q); sda_m = 1'b1; waitq(Q); scl = 1'b1; waitq(Q); b = sda_line; waitq(Q); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(x);
    ack = ~x;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      read_bit(x);
      b[i] = x;
    end
    write_bit(~ack);
  endtask

  task automatic pulse_load(input logic [15:0] t, input logic [15:0] h);
    @(negedge clk);
    t_code = t; h_code = h; code_load = 1'b1;
    @(negedge clk);
    code_load = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] addr, input int n, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [7:0] d2,
                          output logic aack, output logic dack, output logic bmid);
    logic [7:0] d [3];
    logic a;
    d = '{d0, d1, d2};
    i2c_start();
    write_byte({addr, 1'b0}, aack);
    bmid = busy;
    dack = 1'b1;
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], a);
      dack = dack & a;
    end
    i2c_stop();
  endtask

  task automatic do_read(input logic [6:0] addr, input int n, output logic aack,
                         output logic bmid, output logic [47:0] bytes);
    logic [7:0] b;
    bytes = '0;
    i2c_start();
    write_byte({addr, 1'b1}, aack);
    bmid = busy;
    if (aack) begin
      for (int i = 0; i < n; i++) begin
        read_byte(b, i < n - 1);
        bytes[47 - 8 * i -: 8] = b;
      end
    end
    i2c_stop();
  endtask

  task automatic applyStimulus(input vec_t v, output obs_t o);
    int c0, r0, e0;
    c0 = cmd_pulses; r0 = rd_pulses; e0 = oe_cycles;
    o.addr_ack = 1'b0; o.data_ack = 1'b0; o.busy_mid = 1'b0; o.bytes = '0;
    case (v.kind)
      V_LOAD:  pulse_load(v.t, v.h);
      V_WRITE: do_write(v.addr, v.n, v.d0, v.d1, v.d2, o.addr_ack, o.data_ack, o.busy_mid);
      default: do_read(v.addr, v.n, o.addr_ack, o.busy_mid, o.bytes);
    endcase
    waitq(2);
    o.cmd_d = cmd_pulses - c0;
    o.rd_d = rd_pulses - r0;
    o.oe_d = oe_cycles - e0;
    o.busy_end = busy;
    o.oe_end = sda_oe;
    o.cmd = cmd;
  endtask

  task automatic compareVec(input vec_t v, input obs_t o, input string tag);
    checkOutput({tag, ".cmd"}, 48'(o.cmd), 48'(v.exp_cmd));
    checkOutput({tag, ".cmd_valid_pulses"}, 48'(o.cmd_d), 48'(v.exp_cp));
    checkOutput({tag, ".rd_done_pulses"}, 48'(o.rd_d), 48'(v.exp_rp));
    if (v.kind != V_LOAD) begin
      checkOutput({tag, ".addr_ack"}, 48'(o.addr_ack), 48'(v.exp_ack));
      checkOutput({tag, ".busy_mid"}, 48'(o.busy_mid), 48'(v.exp_ack));
      checkOutput({tag, ".busy_after_stop"}, 48'(o.busy_end), 48'd0);
      checkOutput({tag, ".sda_oe_after_stop"}, 48'(o.oe_end), 48'd0);
      if (!v.exp_ack) checkOutput({tag, ".sda_oe_cycles"}, 48'(o.oe_d), 48'd0);
      if (v.kind == V_WRITE && v.n > 0)
        checkOutput({tag, ".data_ack"}, 48'(o.data_ack), 48'(v.exp_ack));
      if (v.kind == V_READ && v.exp_ack)
        checkOutput({tag, ".bytes"}, o.bytes, v.exp_bytes);
    end
  endtask

  initial begin
    vec_t        vecs [9];
    vec_t        v;
    obs_t        o;
    logic        a, bm, bitv;
    logic [7:0]  b;
    logic [47:0] bytes;
    logic        m_ok;
    logic [15:0] m_cmd, rt, rh;
    logic [47:0] m_sample, mask;
    int          r;

    vecs[0] = mk(V_READ,  7'h44, 6, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0, 1'b0, 16'h0000, 0, 0, 48'h0);
    vecs[1] = mk(V_WRITE, 7'h44, 2, 8'h2C, 8'h06, 8'h00, 16'h0, 16'h0, 1'b1, 16'h2C06, 1, 0, 48'h0);
    vecs[2] = mk(V_WRITE, 7'h45, 2, 8'h11, 8'h22, 8'h00, 16'h0, 16'h0, 1'b0, 16'h2C06, 0, 0, 48'h0);
    vecs[3] = mk(V_LOAD,  7'h44, 0, 8'h00, 8'h00, 8'h00, 16'hBEEF, 16'h6666, 1'b1, 16'h2C06, 0, 0, 48'h0);
    vecs[4] = mk(V_READ,  7'h44, 6, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0, 1'b1, 16'h2C06, 0, 1, 48'hBEEF92666693);
    vecs[5] = mk(V_WRITE, 7'h44, 3, 8'h12, 8'h34, 8'h56, 16'h0, 16'h0, 1'b1, 16'h1234, 1, 0, 48'h0);
    vecs[6] = mk(V_WRITE, 7'h44, 1, 8'hAB, 8'h00, 8'h00, 16'h0, 16'h0, 1'b1, 16'h1234, 0, 0, 48'h0);
    vecs[7] = mk(V_WRITE, 7'h44, 2, 8'h30, 8'hA2, 8'h00, 16'h0, 16'h0, 1'b1, 16'h30A2, 1, 0, 48'h0);
    vecs[8] = mk(V_READ,  7'h44, 6, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0, 1'b0, 16'h30A2, 0, 0, 48'h0);

    waitq(5);
    checkOutput("reset.sda_oe", 48'(sda_oe), 48'd0);
    checkOutput("reset.cmd", 48'(cmd), 48'd0);
    checkOutput("reset.cmd_valid", 48'(cmd_valid), 48'd0);
    checkOutput("reset.rd_done", 48'(rd_done), 48'd0);
    checkOutput("reset.busy", 48'(busy), 48'd0);
    rst = 1'b0;
    waitq(4);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], o);
      compareVec(vecs[i], o, $sformatf("vec%0d", i));
    end

    // Master NACKs after byte 2; the following read restarts at byte 0.
    applyStimulus(mk(V_LOAD, 7'h44, 0, 8'h0, 8'h0, 8'h0, 16'hBEEF, 16'h6666, 1'b1, 16'h30A2, 0, 0, 48'h0), o);
    v = mk(V_READ, 7'h44, 2, 8'h0, 8'h0, 8'h0, 16'h0, 16'h0, 1'b1, 16'h30A2, 0, 0, 48'hBEEF_0000_0000);
    applyStimulus(v, o);
    compareVec(v, o, "short_read");
    v = mk(V_READ, 7'h44, 6, 8'h0, 8'h0, 8'h0, 16'h0, 16'h0, 1'b1, 16'h30A2, 0, 1, 48'hBEEF92666693);
    applyStimulus(v, o);
    compareVec(v, o, "restart_read");

    // code_load in the middle of a read only affects the next read.
    i2c_start();
    write_byte(8'h89, a);
    checkOutput("midload.addr_ack", 48'(a), 48'd1);
    bytes = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) pulse_load(16'h1234, 16'h5678);
      read_byte(b, i < 5);
      bytes[47 - 8 * i -: 8] = b;
    end
    i2c_stop();
    checkOutput("midload.old_bytes", bytes, 48'hBEEF92666693);
    v = mk(V_READ, 7'h44, 6, 8'h0, 8'h0, 8'h0, 16'h0, 16'h0, 1'b1, 16'h30A2, 0, 1,
           {16'h1234, ref_crc(16'h1234), 16'h5678, ref_crc(16'h5678)});
    applyStimulus(v, o);
    compareVec(v, o, "midload.new_read");

    // Reset while the responder is driving a 0 data bit.
    i2c_start();
    write_byte(8'h89, a);
    read_bit(bitv);
    checkOutput("rst_tx.bit7", 48'(bitv), 48'd0);
    waitq(Q);
    checkOutput("rst_tx.driving", 48'(sda_oe), 48'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_tx.oe_same_cycle", 48'(sda_oe), 48'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_tx.oe_next_cycle", 48'(sda_oe), 48'd0);
    waitq(2);
    rst = 1'b0;
    waitq(2);
    checkOutput("rst_tx.cmd", 48'(cmd), 48'd0);
    checkOutput("rst_tx.busy", 48'(busy), 48'd0);
    v = mk(V_WRITE, 7'h44, 2, 8'h12, 8'h34, 8'h00, 16'h0, 16'h0, 1'b1, 16'h1234, 1, 0, 48'h0);
    applyStimulus(v, o);
    compareVec(v, o, "rst_tx.after");

    // Random transactions against a transaction-level model.
    m_ok = 1'b0;
    m_cmd = 16'h1234;
    m_sample = '0;
    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 9));
      v.addr = 7'h44;
      if ($urandom_range(0, 3) == 0) begin
        v.addr = 7'($urandom_range(0, 127));
        if (v.addr == 7'h44) v.addr = 7'h45;
      end
      v.d0 = 8'($urandom); v.d1 = 8'($urandom); v.d2 = 8'($urandom);
      v.t = 16'($urandom); v.h = 16'($urandom);
      v.exp_cp = 0; v.exp_rp = 0; v.exp_bytes = '0;
      if (r < 2) begin
        v.kind = V_LOAD; v.n = 0; v.exp_ack = 1'b1;
        m_sample = {v.t, ref_crc(v.t), v.h, ref_crc(v.h)};
        m_ok = 1'b1;
      end else if (r < 6) begin
        v.kind = V_WRITE;
        v.n = int'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin v.d0 = 8'h30; v.d1 = 8'hA2; end
        v.exp_ack = (v.addr == 7'h44);
        if (v.exp_ack && v.n >= 2) begin
          m_cmd = {v.d0, v.d1};
          v.exp_cp = 1;
          if (m_cmd == 16'h30A2) m_ok = 1'b0;
        end
      end else begin
        v.kind = V_READ;
        v.n = int'($urandom_range(1, 6));
        v.exp_ack = (v.addr == 7'h44) && m_ok;
        mask = ~48'h0 << (8 * (6 - v.n));
        v.exp_bytes = m_sample & mask;
        v.exp_rp = (v.exp_ack && v.n == 6) ? 1 : 0;
      end
      v.exp_cmd = m_cmd;
      rt = v.t; rh = v.h;
      applyStimulus(v, o);
      compareVec(v, o, $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
